// File: rtl/bus_arbiter_16_pkg.sv
// Shared definitions for the 16-way round-robin bus arbiter.
// Holds the request/index widths, the FSM state encodings, the registered
// output bundle and a one-hot helper. Imported by the interface, the
// priority picker and the top level.
package bus_arbiter_16_pkg;

  localparam int unsigned ARB_NREQ = 16;
  localparam int unsigned ARB_IDXW = 4;

  // FSM encodings kept as plain constants for compatibility with older blocks
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_BUSY = 2'd1;
  localparam logic [1:0] ARB_GAP  = 2'd2;

  typedef logic [ARB_NREQ-1:0] reqVec_t;
  typedef logic [ARB_IDXW-1:0] idx_t;

  // Registered outputs of the arbiter, moved as one bundle
  typedef struct packed {
    reqVec_t grant;
    idx_t    sel;
    logic    busy;
    logic    timeout;
  } arbOut_t;

  // One-hot vector with bit idx set
  function automatic reqVec_t idxToOneHot(input idx_t idx);
    return ARB_NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter_16_if.sv
// Request/grant bundle between the requesters and the bus arbiter.
//   req        requester i wants (or keeps) the bus
//   s3..s0     mux select lines, {s3,s2,s1,s0} = owner index
//   grant      one-hot ownership vector
//   bus_busy   1 while any grant is active
//   timeout    one-cycle pulse on a forced release
// Modports: master = arbiter side (drives select/grant), slave = requester side.
interface bus_arbiter_16_if;
  import bus_arbiter_16_pkg::*;

  reqVec_t req;
  logic    s3;
  logic    s2;
  logic    s1;
  logic    s0;
  reqVec_t grant;
  logic    bus_busy;
  logic    timeout;

  modport master (
    input  req,
    output s3, s2, s1, s0, grant, bus_busy, timeout
  );

  modport slave (
    output req,
    input  s3, s2, s1, s0, grant, bus_busy, timeout
  );

endinterface

// File: rtl/bus_arbiter_16_rr_pick16.sv
// Rotating-priority search over 16 request lines.
// Ports:
//   req   in  16  request vector
//   last  in  4   index of the previous owner (lowest priority this round)
//   win   out 4   first requesting index scanning upward from last+1 with wrap
//   any   out 1   at least one request is active (win is meaningful only then)
// Purely combinational; the previous owner is reached last, so it wins again
// only when nobody else is requesting.
module bus_arbiter_16_rr_pick16
  import bus_arbiter_16_pkg::*;
(
  input  reqVec_t req,
  input  idx_t    last,
  output idx_t    win,
  output logic    any
);

  idx_t candIdx;
  logic found;

  // Scan offsets 1..16; 4-bit addition supplies the 15 -> 0 wrap for free
  always_comb begin
    win     = '0;
    found   = 1'b0;
    candIdx = '0;
    for (int k = 1; k <= int'(ARB_NREQ); k++) begin
      candIdx = last + ARB_IDXW'(k);
      if (!found && req[candIdx]) begin
        win   = candIdx;
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/bus_arbiter_16.sv
// Round-robin arbiter and sequencer for the 16:1 19-bit CPU bus mux.
// Grants the bus to one requester at a time, drives the mux select lines and
// a one-hot grant, and inserts one dead turnaround cycle between owners.
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    bus_arbiter_16_if.master (req in; s3..s0, grant, bus_busy, timeout out)
// Parameters:
//   MAX_HOLD  max consecutive BUSY cycles per grant when the timeout is built in (2..255)
//   CNT_W     hold-counter width, must hold MAX_HOLD-1
// Optional feature: define BUS_ARB_TIMEOUT_EN to force release of an owner
// that holds the bus for MAX_HOLD cycles; otherwise timeout stays 0 and an
// owner may hold the bus indefinitely.
module bus_arbiter_16
  import bus_arbiter_16_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 64,
  parameter int unsigned CNT_W    = 8
)(
  input  logic              clk,
  input  logic              rst_n,
  bus_arbiter_16_if.master  bus
);

  localparam logic [CNT_W-1:0] HoldSat = '1;

  // Elaboration-time parameter sanity
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : gBadMaxHold
    $error("bus_arbiter_16: MAX_HOLD must be within 2..255");
  end
  if (((MAX_HOLD - 1) >> CNT_W) != 0) begin : gBadCntW
    $error("bus_arbiter_16: CNT_W too narrow for MAX_HOLD-1");
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HoldLimit = CNT_W'(MAX_HOLD - 1);
`endif

  logic [1:0]       state;
  logic [1:0]       stateNxt;
  arbOut_t          outR;
  arbOut_t          outNxt;
  idx_t             lastR;
  idx_t             lastNxt;
  logic [CNT_W-1:0] holdCnt;
  logic [CNT_W-1:0] holdNxt;
  idx_t             win;
  logic             anyReq;
  logic             ownerReq;

  bus_arbiter_16_rr_pick16 uPick (
    .req  (bus.req),
    .last (lastR),
    .win  (win),
    .any  (anyReq)
  );

  // Current owner is still asking for the bus
  assign ownerReq = bus.req[outR.sel];

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB_IDLE;
      outR    <= '0;
      lastR   <= 4'hF;
      holdCnt <= '0;
    end else begin
      state   <= stateNxt;
      outR    <= outNxt;
      lastR   <= lastNxt;
      holdCnt <= holdNxt;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    stateNxt       = state;
    outNxt         = outR;
    outNxt.timeout = 1'b0;
    lastNxt        = lastR;
    holdNxt        = holdCnt;

    case (state)
      // IDLE and GAP both arbitrate; sel only moves when a grant is issued
      ARB_IDLE, ARB_GAP: begin
        if (anyReq) begin
          stateNxt     = ARB_BUSY;
          outNxt.grant = idxToOneHot(win);
          outNxt.sel   = win;
          outNxt.busy  = 1'b1;
          lastNxt      = win;
          holdNxt      = '0;
        end else begin
          stateNxt     = ARB_IDLE;
          outNxt.grant = '0;
          outNxt.busy  = 1'b0;
        end
      end

      // Owner keeps the bus until it drops req; other requests are ignored
      ARB_BUSY: begin
        if (!ownerReq) begin
          stateNxt     = ARB_GAP;
          outNxt.grant = '0;
          outNxt.busy  = 1'b0;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (holdCnt == HoldLimit) begin
          stateNxt       = ARB_GAP;
          outNxt.grant   = '0;
          outNxt.busy    = 1'b0;
          outNxt.timeout = 1'b1;
        end
`endif
        else if (holdCnt != HoldSat) begin
          holdNxt = holdCnt + CNT_W'(1);
        end
      end

      default: begin
        stateNxt     = ARB_IDLE;
        outNxt.grant = '0;
        outNxt.busy  = 1'b0;
      end
    endcase
  end

  assign bus.grant                        = outR.grant;
  assign {bus.s3, bus.s2, bus.s1, bus.s0} = outR.sel;
  assign bus.bus_busy                     = outR.busy;
  assign bus.timeout                      = outR.timeout;

endmodule
